// File: rtl/apb_pkg.sv
// apb_pkg: FSM state encoding and APB width constants shared by bridge and slave blocks
package apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 10;
  localparam int APB_CNT_W = 4;
endpackage

// File: rtl/apb_ram_bytewe.sv
// apb_ram_bytewe: word storage with combinational read and byte-enabled synchronous write
module apb_ram_bytewe #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_W/8; i++)
        if (strb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_ram.sv
// apb_slave_ram: APB slave RAM with fixed wait states, byte strobes and address error detection
module apb_slave_ram import apb_pkg::*; #(
  parameter int DATA_W = APB_DATA_W,
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                PCLK,
  input  logic                RESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic                PREADY,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PSLVERR
);
  localparam int SW = DATA_W/8;
  localparam int BW = $clog2(SW);
  localparam int RAW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  apb_state_e state, nxt;
  logic [APB_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [RAW-1:0] idx_q;
  logic wr_q, err_q, err, setup, we;
  logic [DATA_W-1:0] rdata;
  assign idx = PADDR >> BW;
  assign err = (32'(idx) >= 32'(DEPTH)) || ((PADDR & ADDR_W'(SW-1)) != '0);
  assign setup = PSEL && !PENABLE;
  always_ff @(posedge PCLK)
    state <= RESET ? IDLE : nxt;
  // leaving WAIT without a held access phase is an abort, same as deselect
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE: nxt = setup ? (WAIT_STATES == 0 ? DONE : WAIT) : IDLE;
      WAIT: nxt = !(PSEL && PENABLE) ? IDLE : (cnt == APB_CNT_W'(WAIT_STATES-1)) ? DONE : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_comb
    we = state == DONE && PSEL && wr_q && !err_q && !RESET;
  always_ff @(posedge PCLK)
    if (RESET) begin
      cnt <= '0;
      PREADY <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA <= '0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      PREADY <= nxt == DONE;
      PSLVERR <= nxt == DONE && (state == IDLE ? err : err_q);
      if (state == IDLE && setup) begin
        idx_q <= idx[RAW-1:0];
        wr_q <= PWRITE;
        err_q <= err;
        PRDATA <= (err || PWRITE) ? '0 : rdata;
      end
    end
  apb_ram_bytewe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(PCLK),
    .we(we),
    .waddr(idx_q),
    .wdata(PWDATA),
    .strb(PSTRB),
    .raddr(idx[RAW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_apb_slave_ram.sv
// tb_apb_slave_ram: directed checks of the APB slave RAM with 2 and 0 wait states
module tb_apb_slave_ram;
  logic clk = 1'b0;
  logic rst, penable, pwrite;
  logic [1:0] psel;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0] pstrb;
  logic rdy0, rdy1, err0, err1;
  logic [31:0] rd0, rd1;
  logic [31:0] rd;
  logic e;
  int n;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  // 12-bit address so that 0x400 (index 256) is reachable
  apb_slave_ram #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(2)) u0 (
    .PCLK(clk), .RESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0)
  );
  apb_slave_ram #(.WAIT_STATES(0)) u1 (
    .PCLK(clk), .RESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr[9:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(rdy1), .PRDATA(rd1), .PSLVERR(err1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setup(input int d, input logic w, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] s);
    @(posedge clk); #1;
    psel = d == 0 ? 2'b01 : 2'b10;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = wd;
    pstrb = s;
  endtask
  task automatic xfer(input int d, input logic w, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] r, output logic er, output int cyc);
    setup(d, w, a, wd, s);
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(d == 0 ? rdy0 : rdy1) && cyc < 20);
    r = d == 0 ? rd0 : rd1;
    er = d == 0 ? err0 : err1;
  endtask
  task automatic idle();
    @(posedge clk); #1;
    psel = 2'b00;
    penable = 1'b0;
  endtask
  initial begin
    rst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_slverr", {31'd0, err0}, 32'd0);
    chk("rst_prdata", rd0, 32'd0);
    chk("rst_prdata1", rd1, 32'd0);
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, e, n);
    chk("wr1_cycles", n, 3);
    chk("wr1_err", {31'd0, e}, 32'd0);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, e, n);
    chk("rd1_cycles", n, 3);
    chk("rd1_data", rd, 32'hDEADBEEF);
    chk("rd1_err", {31'd0, e}, 32'd0);
    xfer(0, 1'b1, 12'h010, 32'h000000AA, 4'h1, rd, e, n);
    chk("wr_strb_prdata0", rd, 32'd0);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, e, n);
    chk("rd_strb_data", rd, 32'hDEADBEAA);
    xfer(0, 1'b1, 12'h000, 32'h11223344, 4'hF, rd, e, n);
    xfer(0, 1'b1, 12'h400, 32'hFFFFFFFF, 4'hF, rd, e, n);
    chk("wr_oob_err", {31'd0, e}, 32'd1);
    chk("wr_oob_cycles", n, 3);
    chk("wr_oob_prdata", rd, 32'd0);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, e, n);
    chk("rd_after_oob", rd, 32'hDEADBEAA);
    xfer(0, 1'b0, 12'h002, 32'h0, 4'h0, rd, e, n);
    chk("rd_misal_err", {31'd0, e}, 32'd1);
    chk("rd_misal_data", rd, 32'd0);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, e, n);
    chk("rd_idx0_kept", rd, 32'h11223344);
    chk("rd_idx0_err", {31'd0, e}, 32'd0);
    idle();
    xfer(1, 1'b1, 12'h004, 32'h55AA55AA, 4'hF, rd, e, n);
    chk("ws0_wr_cycles", n, 1);
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, rd, e, n);
    chk("ws0_rd_cycles", n, 1);
    chk("ws0_rd_data", rd, 32'h55AA55AA);
    chk("ws0_rd_err", {31'd0, e}, 32'd0);
    idle();
    xfer(0, 1'b1, 12'h020, 32'hCAFEF00D, 4'hF, rd, e, n);
    setup(0, 1'b1, 12'h020, 32'h12345678, 4'hF);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ready", {31'd0, rdy0}, 32'd0);
    end
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, e, n);
    chk("abort_cycles", n, 3);
    chk("abort_kept", rd, 32'hCAFEF00D);
    xfer(0, 1'b1, 12'h020, 32'h12345678, 4'hF, rd, e, n);
    chk("rstw_done", {31'd0, rdy0}, 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", {31'd0, rdy0}, 32'd0);
    chk("rstw_slverr", {31'd0, err0}, 32'd0);
    chk("rstw_prdata", rd0, 32'd0);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, e, n);
    chk("rstw_kept", rd, 32'hCAFEF00D);
    setup(0, 1'b0, 12'h010, 32'h0, 4'h0);
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("rstr_loaded", rd0, 32'hDEADBEAA);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rstr_prdata", rd0, 32'd0);
    chk("rstr_ready", {31'd0, rdy0}, 32'd0);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, e, n);
    chk("post_rst_cycles", n, 3);
    chk("post_rst_data", rd, 32'hDEADBEAA);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
